id_stage_queue: RTL and testbench
=================================

// Module: id_stage_queue
// PURPOSE
//  Parametrised multi-lane IF->ID pipeline-stage buffer. Holds up to DEPTH issue groups,
//  each with LANES per-lane valid bits and one shared payload bus. Replaces the single
//  register stage so that upstream allowin depends only on a registered occupancy count,
//  not combinationally on downstream allowin. Excep/branch flush empties the buffer.
// PARAMETERS
//  DATA_W  64  width of the shared payload bus per group (set to IftToNextBusWidth)
//  LANES   2   issue lanes per group (valid bits per entry), >=1
//  DEPTH   2   entries, power of two, >=2
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous active-low reset
//  pre_valid_i     in   LANES   per-lane valid from previous stage
//  pre_bus_i       in   DATA_W  payload from previous stage
//  pre_allowin_o   out  1       buffer can accept a group this cycle
//  now_valid_o     out  LANES   per-lane valid of head group to ID logic
//  now_bus_o       out  DATA_W  payload of head group
//  now_allowin_i   in   1       ID stage consumes head group this cycle
//  excep_flush_i   in   1       exception flush
//  branch_flush_i  in   1       branch-mispredict flush
//  count_o         out  CNT_W   occupancy, CNT_W = $clog2(DEPTH+1)
// BEHAVIOUR
//  - Reset (async, rst_n=0): count=0, rd/wr pointers=0, all entry masks and payloads=0;
//    so now_valid_o=0, now_bus_o=0, pre_allowin_o=1, count_o=0.
//  - pre_allowin_o = (count != DEPTH); function of registered count only.
//  - push = (|pre_valid_i) & pre_allowin_o & ~flush. All-zero masks are never stored.
//  - pop  = (count != 0) & now_allowin_i & ~flush.
//  - flush = excep_flush_i | branch_flush_i. On the next edge: count=0, pointers=0, and
//    the same-cycle push and pop are discarded. Stored payloads are don't-care after a
//    flush; outputs read as empty.
//  - now_valid_o = (count != 0) ? mask[rd_ptr] : 0; now_bus_o = payload[rd_ptr]
//    (payload is don't-care when now_valid_o=0).
//  - Latency: a group pushed at edge t is visible at the head from t+1. There is no
//    combinational bypass from pre_* to now_*, even when empty.
//  - Order is strict FIFO. Push with pop in the same cycle: count unchanged, and both
//    pointers advance.
//  - Full: pre_allowin_o=0. A pop in that cycle does not enable a same-cycle push; the
//    push is accepted one cycle later.
//  - Empty: now_allowin_i is ignored; count does not underflow.
//  - Pointers wrap modulo DEPTH. Lane masks are stored exactly as presented; partial
//    masks (e.g. 2'b01) are legal.
//  - Reset asserted mid-operation: buffer cleared immediately; no stale output after release.
// TESTING
//  1 Reset, then push mask 2'b11, bus 0xA5 with ID stalled -> at t+1 now_valid_o=11,
//    now_bus_o=0xA5, count_o=1.
//  2 Stall ID and push 3 groups (DEPTH=2) -> pre_allowin_o=0 after 2nd push; 3rd held
//    upstream; release ID -> heads in order, 3rd accepted one cycle after 1st pop.
//  3 Continuous push + pop for 10 cycles -> count_o stays 1; outputs are the inputs
//    delayed 1 cycle; pointers wrap with no loss.
//  4 count_o=2, assert branch_flush_i with pre_valid_i=11 -> next cycle count_o=0,
//    now_valid_o=0, pre_allowin_o=1, flushed-cycle group not stored.
//  5 Push mask 2'b01 then 2'b10 -> head shows 01 then 10. Push mask 00 -> count unchanged.
//  6 Drop rst_n asynchronously with count_o=2 -> outputs go to reset values before the
//    next clk edge.

Source files
------------

// File: rtl/id_stage_queue.sv
`default_nettype none
// ============================================================================
// id_stage_queue : multi-lane IF->ID stage buffer holding DEPTH issue groups;
//                  upstream allowin is derived from the registered count only.
// Revision: 1.0
// ============================================================================
module id_stage_queue #(
  parameter  int DATA_W = 64,
  parameter  int LANES  = 2,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANES-1:0]  pre_valid_i,
  input  logic [DATA_W-1:0] pre_bus_i,
  output logic              pre_allowin_o,
  output logic [LANES-1:0]  now_valid_o,
  output logic [DATA_W-1:0] now_bus_o,
  input  logic              now_allowin_i,
  input  logic              excep_flush_i,
  input  logic              branch_flush_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [LANES-1:0]  r_mask [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [CNT_W-1:0]  r_cnt;

  logic w_flush;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_flush       = excep_flush_i | branch_flush_i;
  assign w_empty       = (r_cnt == '0);
  assign pre_allowin_o = (r_cnt != C_FULL);
  // A pop in a full cycle cannot open room for a same-cycle push: allowin is registered-only.
  assign w_push        = (|pre_valid_i) & pre_allowin_o & ~w_flush;
  assign w_pop         = ~w_empty & now_allowin_i & ~w_flush;

  assign now_valid_o   = w_empty ? '0 : r_mask[r_rd];
  assign now_bus_o     = r_data[r_rd];
  assign count_o       = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mask[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (w_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mask[r_wr] <= pre_valid_i;
        r_data[r_wr] <= pre_bus_i;
        r_wr         <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_queue.sv
`default_nettype none
// ============================================================================
// tb_id_stage_queue : vector table plus scoreboard for id_stage_queue
// Revision: 1.0
// ============================================================================
module tb_id_stage_queue;

  localparam int DATA_W = 64;
  localparam int LANES  = 2;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic [LANES-1:0]  pre_valid_i;
  logic [DATA_W-1:0] pre_bus_i;
  logic              pre_allowin_o;
  logic [LANES-1:0]  now_valid_o;
  logic [DATA_W-1:0] now_bus_o;
  logic              now_allowin_i;
  logic              excep_flush_i;
  logic              branch_flush_i;
  logic [CNT_W-1:0]  count_o;

  id_stage_queue #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pre_valid_i    (pre_valid_i),
    .pre_bus_i      (pre_bus_i),
    .pre_allowin_o  (pre_allowin_o),
    .now_valid_o    (now_valid_o),
    .now_bus_o      (now_bus_o),
    .now_allowin_i  (now_allowin_i),
    .excep_flush_i  (excep_flush_i),
    .branch_flush_i (branch_flush_i),
    .count_o        (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] bus;
  } grp_t;

  typedef struct {
    logic [LANES-1:0]  v;
    logic [DATA_W-1:0] bus;
    logic              alw;
    logic              ef;
    logic              bf;
    int                exp_cnt;
  } vec_t;

  grp_t sb[$];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check head/count against the scoreboard, then advance the model.
  task automatic step(input logic [LANES-1:0] v, input logic [DATA_W-1:0] bus,
                      input logic alw, input logic ef, input logic bf, input int exp_cnt);
    bit flush, push, pop;
    grp_t g;
    @(negedge clk);
    pre_valid_i    = v;
    pre_bus_i      = bus;
    now_allowin_i  = alw;
    excep_flush_i  = ef;
    branch_flush_i = bf;
    #1;
    chk("count", 64'(count_o), 64'(sb.size()));
    chk("pre_allowin", 64'(pre_allowin_o), 64'(sb.size() != DEPTH));
    if (sb.size() == 0) begin
      chk("empty_valid", 64'(now_valid_o), 64'd0);
    end
    flush = ef | bf;
    push  = (|v) && (sb.size() < DEPTH) && !flush;
    pop   = (sb.size() > 0) && alw && !flush;
    if (pop) begin
      g = sb.pop_front();
      chk("head_valid", 64'(now_valid_o), 64'(g.mask));
      chk("head_bus", now_bus_o, g.bus);
    end
    if (flush) sb.delete();
    if (push) begin
      g.mask = v;
      g.bus  = bus;
      sb.push_back(g);
    end
    @(posedge clk);
    #1;
    chk("count_after", 64'(count_o), 64'(exp_cnt));
  endtask

  vec_t vecs[17];

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{2'b11, 64'hA5, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{2'b11, 64'hB1, 1'b0, 1'b0, 1'b0, 2};
    vecs[2]  = '{2'b11, 64'hC2, 1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{2'b11, 64'hC2, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{2'b11, 64'hC2, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{2'b00, 64'h0,  1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{2'b01, 64'h11, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{2'b10, 64'h22, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{2'b00, 64'h0,  1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{2'b00, 64'h33, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{2'b00, 64'h0,  1'b1, 1'b0, 1'b0, 0};
    vecs[11] = '{2'b11, 64'hD1, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{2'b11, 64'hD2, 1'b0, 1'b0, 1'b0, 2};
    vecs[13] = '{2'b11, 64'hD3, 1'b1, 1'b0, 1'b1, 0};
    vecs[14] = '{2'b00, 64'h0,  1'b1, 1'b0, 1'b0, 0};
    vecs[15] = '{2'b11, 64'hE1, 1'b0, 1'b1, 1'b0, 0};
    vecs[16] = '{2'b00, 64'h0,  1'b1, 1'b0, 1'b0, 0};

    rst_n          = 1'b0;
    pre_valid_i    = '0;
    pre_bus_i      = '0;
    now_allowin_i  = 1'b0;
    excep_flush_i  = 1'b0;
    branch_flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_allowin", 64'(pre_allowin_o), 64'd1);
    chk("rst_valid", 64'(now_valid_o), 64'd0);
    chk("rst_bus", now_bus_o, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].v, vecs[i].bus, vecs[i].alw, vecs[i].ef, vecs[i].bf, vecs[i].exp_cnt);
    end

    // Streaming: one push and one pop per cycle wraps the pointers repeatedly.
    step(2'b11, 64'hF00, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      step(2'(i % 3 + 1), 64'hF01 + 64'(i), 1'b1, 1'b0, 1'b0, 1);
    end
    step(2'b00, 64'h0, 1'b1, 1'b0, 1'b0, 0);

    // Asynchronous reset while holding two groups.
    step(2'b11, 64'h71, 1'b0, 1'b0, 1'b0, 1);
    step(2'b10, 64'h72, 1'b0, 1'b0, 1'b0, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_count", 64'(count_o), 64'd0);
    chk("async_valid", 64'(now_valid_o), 64'd0);
    chk("async_bus", now_bus_o, 64'd0);
    chk("async_allowin", 64'(pre_allowin_o), 64'd1);
    sb.delete();
    pre_valid_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 64'h0, 1'b1, 1'b0, 1'b0, 0);
    step(2'b01, 64'h81, 1'b0, 1'b0, 1'b0, 1);
    step(2'b00, 64'h0, 1'b1, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
